cp0_exc_sched: RTL and testbench
================================

// Module: cp0_exc_sched
// PURPOSE
//  Exception/interrupt scheduler in front of the CP0 register file. Arbitrates
//  synchronous traps (syscall, break, teq) and external IRQ lines, then issues
//  one exception or eret command pulse per event, with cause code, to CP0.
//  Stalls the PC/IR path while CP0 commits EPC/Status/Cause and the fetch
//  address redirects.
// PARAMETERS
//  NUM_IRQ      4  number of external interrupt lines (1..8)
//  HOLD_CYCLES  2  stall cycles after the command pulse (1..15)
// PORTS
//  clk          in   1        clock
//  reset        in   1        async, active-low reset
//  syscall_req  in   1        decode: syscall in IR (level, held while stalled)
//  break_req    in   1        decode: break in IR
//  teq_req      in   1        decode: teq condition true
//  eret_req     in   1        decode: eret in IR
//  irq          in   NUM_IRQ  external interrupt lines, rising-edge sensitive
//  status_ie    in   1        CP0 Status[0] (global interrupt enable)
//  exception    out  1        1-cycle pulse to CP0 exception input
//  eret         out  1        1-cycle pulse to CP0 eret input
//  cause        out  5        ExcCode to CP0; valid while exception=1
//  stall        out  1        freeze PC/IR
//  irq_pending  out  NUM_IRQ  latched, unserviced IRQ edges
//  busy         out  1        FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, irq_pending=0, FSM=IDLE, synchroniser and edge flops 0.
//  FSM: IDLE -> CMD (1 cycle) -> HOLD (HOLD_CYCLES cycles) -> IDLE.
//  - IDLE: a request is sampled at a clock edge. Next cycle is CMD with a
//    registered exception or eret pulse and stall=1. Latency is 1 cycle.
//  - stall=1 in CMD and in all HOLD cycles. stall=0 in IDLE.
//  - No new request is accepted outside IDLE. Sync requests stay asserted
//    upstream because IR is frozen. IRQ edges keep latching.
//  Priority, highest first (evaluated only in IDLE):
//  - syscall: cause 5'b01000
//  - break: cause 5'b01001
//  - teq: cause 5'b01101
//  - eret: no cause
//  - IRQ: lowest index first, cause 5'b00000
//  Gating:
//  - Sync traps and IRQs are taken only if status_ie=1.
//  - A sync trap with status_ie=0 is dropped (no pulse, no stall).
//  - IRQs with status_ie=0 stay pending.
//  - eret is taken regardless of status_ie.
//  IRQ edge detect:
//  - An irq 0->1 edge sets irq_pending[k].
//  - irq_pending[k] clears on the cycle of the CMD pulse that serviced k.
//  - A new edge on k in that same cycle wins: the bit stays 1.
//  Simultaneous events: eret plus a sync trap means the trap wins and eret is
//  dropped. Multiple sync traps means the highest-priority trap wins and the
//  others are dropped.
//  A 5-bit HOLD counter counts HOLD_CYCLES-1 down to 0, then returns to IDLE.
//  Reset mid-operation (CMD/HOLD): immediate return to IDLE. Pulses and stall
//  drop asynchronously and pending IRQs are lost.
// CONFIGURATION
//  CP0_EXC_IRQ_SYNC_EN
//  - Defined: each irq line passes a 2-flop synchroniser before edge detect,
//    adding 2 cycles of IRQ latency.
//  - Undefined: irq is edge-detected directly, for synchronous sources only.
// TESTING
//  Assert syscall_req with status_ie=1 -> next cycle exception=1 and
//  cause=5'h08. stall=1 for 1+2 cycles, then busy=0.
//  Assert syscall_req, break_req and eret_req together -> one exception pulse
//  with cause=5'h08 and no eret pulse.
//  Pulse irq[2] and irq[1] in the same cycle with status_ie=1 -> first
//  service sets cause=0 and clears pending[1]. After IDLE, a second exception
//  clears pending[2].
//  Pulse irq[0] with status_ie=0 -> irq_pending=4'b0001 and no pulse. Raise
//  status_ie -> exception 1 cycle later.
//  Assert eret_req with status_ie=0 -> eret=1 for 1 cycle and stall 3 cycles.
//  Drop reset during HOLD -> stall=0 and busy=0 immediately. Sync-enabled
//  build: irq edge -> pending 3 cycles later.

Source files
------------

// File: rtl/cp0_exc_sched_if.sv
// Bundle between the decode/CP0 side and the exception scheduler.
// The master drives trap requests, IRQ lines and Status.IE; the slave answers with command pulses and stall.
interface cp0_exc_sched_if #(
    parameter int NUM_IRQ = 4
);
    logic               syscall_req;
    logic               break_req;
    logic               teq_req;
    logic               eret_req;
    logic [NUM_IRQ-1:0] irq;
    logic               status_ie;
    logic               exception;
    logic               eret;
    logic [4:0]         cause;
    logic               stall;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               busy;

    modport master (
        output syscall_req, break_req, teq_req, eret_req, irq, status_ie,
        input  exception, eret, cause, stall, irq_pending, busy
    );

    modport slave (
        input  syscall_req, break_req, teq_req, eret_req, irq, status_ie,
        output exception, eret, cause, stall, irq_pending, busy
    );
endinterface

// File: rtl/cp0_exc_sched.sv
// Exception/interrupt scheduler: one CP0 exception or eret pulse per event, then holds the PC/IR stall.
// Optional CP0_EXC_IRQ_SYNC_EN adds a 2-flop synchroniser on every irq line ahead of edge detection.
module cp0_exc_sched #(
    parameter int NUM_IRQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_sched_if.slave bus
);
    localparam logic [4:0] CAUSE_INT = 5'b00000;
    localparam logic [4:0] CAUSE_SYS = 5'b01000;
    localparam logic [4:0] CAUSE_BRK = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ = 5'b01101;
    localparam logic [4:0] HOLD_LOAD = 5'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CMD, HOLD} state_t;

    state_t             state_reg;
    logic [4:0]         hold_cnt_reg;
    logic               exception_reg;
    logic               eret_reg;
    logic [4:0]         cause_reg;
    logic               stall_reg;
    logic               busy_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] irq_sel;
    logic [NUM_IRQ-1:0] irq_clr;
    logic               trap_take;
    logic               irq_any;
    logic               irq_take;
    logic [4:0]         trap_cause;

`ifdef CP0_EXC_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg;
    logic [NUM_IRQ-1:0] sync2_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= bus.irq;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_src = sync2_reg;
`else
    assign irq_src = bus.irq;
`endif

    // A fresh edge in the servicing cycle re-arms the bit, so it is OR-ed in after the clear.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
            assign irq_edge[gi]     = irq_src[gi] & ~irq_prev_reg[gi];
            assign pending_next[gi] = (pending_reg[gi] & ~irq_clr[gi]) | irq_edge[gi];
        end
    endgenerate

    always_comb begin
        trap_take  = bus.status_ie & (bus.syscall_req | bus.break_req | bus.teq_req);
        trap_cause = bus.syscall_req ? CAUSE_SYS : (bus.break_req ? CAUSE_BRK : CAUSE_TEQ);
        irq_sel    = '0;
        irq_any    = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!irq_any && pending_reg[k]) begin
                irq_sel[k] = 1'b1;
                irq_any    = 1'b1;
            end
        end
        irq_take = bus.status_ie & irq_any;
        irq_clr  = '0;
        if (state_reg == IDLE && !trap_take && !bus.eret_req && irq_take) begin
            irq_clr = irq_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_reg <= '0;
            pending_reg  <= '0;
        end else begin
            irq_prev_reg <= irq_src;
            pending_reg  <= pending_next;
        end
    end

    // Disabled sync traps fall through to eret/IRQ arbitration without stalling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            hold_cnt_reg  <= '0;
            exception_reg <= 1'b0;
            eret_reg      <= 1'b0;
            cause_reg     <= '0;
            stall_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            exception_reg <= 1'b0;
            eret_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trap_take) begin
                        exception_reg <= 1'b1;
                        cause_reg     <= trap_cause;
                    end else if (bus.eret_req) begin
                        eret_reg  <= 1'b1;
                        cause_reg <= '0;
                    end else if (irq_take) begin
                        exception_reg <= 1'b1;
                        cause_reg     <= CAUSE_INT;
                    end
                    if (trap_take || bus.eret_req || irq_take) begin
                        state_reg <= CMD;
                        stall_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                CMD: begin
                    state_reg    <= HOLD;
                    hold_cnt_reg <= HOLD_LOAD;
                    cause_reg    <= '0;
                end
                HOLD: begin
                    if (hold_cnt_reg == 5'd0) begin
                        state_reg <= IDLE;
                        stall_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 5'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    stall_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exception   = exception_reg;
    assign bus.eret        = eret_reg;
    assign bus.cause       = cause_reg;
    assign bus.stall       = stall_reg;
    assign bus.busy        = busy_reg;
    assign bus.irq_pending = pending_reg;
endmodule

// File: tb/tb_cp0_exc_sched.sv
// Bench for cp0_exc_sched: vector table, hand-written corner sequences and a random run
// against a cycle-count reference model.
module tb_cp0_exc_sched;
    localparam int NIRQ = 4;
    localparam int HOLD = 2;
`ifdef CP0_EXC_IRQ_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic clk;
    logic reset;

    cp0_exc_sched_if #(.NUM_IRQ(NIRQ)) bus ();

    cp0_exc_sched #(.NUM_IRQ(NIRQ), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: remaining stall cycles plus a set of pending IRQ lines.
    int            m_left;
    bit            m_exc;
    bit            m_eret;
    bit [4:0]      m_cause;
    bit [NIRQ-1:0] m_pend;
    bit [NIRQ-1:0] m_prev;
    bit [NIRQ-1:0] m_h0;
    bit [NIRQ-1:0] m_h1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_exc   = 1'b0;
        m_eret  = 1'b0;
        m_cause = '0;
        m_pend  = '0;
        m_prev  = '0;
        m_h0    = '0;
        m_h1    = '0;
    endtask

    task automatic model_edge();
        bit [NIRQ-1:0] src;
        bit [NIRQ-1:0] clr;
        bit            trap;
        src    = (SYNC_DLY == 0) ? bus.irq : m_h1;
        m_h1   = m_h0;
        m_h0   = bus.irq;
        clr    = '0;
        m_exc  = 1'b0;
        m_eret = 1'b0;
        if (m_left > 0) begin
            m_left--;
        end else begin
            trap = bus.status_ie && (bus.syscall_req || bus.break_req || bus.teq_req);
            if (trap) begin
                m_exc   = 1'b1;
                m_cause = bus.syscall_req ? 5'd8 : (bus.break_req ? 5'd9 : 5'd13);
            end else if (bus.eret_req) begin
                m_eret = 1'b1;
            end else if (bus.status_ie && m_pend != 0) begin
                for (int k = 0; k < NIRQ; k++) begin
                    if (m_pend[k]) begin
                        clr[k] = 1'b1;
                        break;
                    end
                end
                m_exc   = 1'b1;
                m_cause = 5'd0;
            end
            if (m_exc || m_eret) m_left = 1 + HOLD;
        end
        m_pend = (m_pend & ~clr) | (src & ~m_prev);
        m_prev = src;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            step();
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=1 want busy=0 within 20 cycles", tag);
        end
    endtask

    typedef struct {
        bit       sys;
        bit       brk;
        bit       teq;
        bit       ert;
        bit       ie;
        bit       exc;
        bit       ert_o;
        bit [4:0] cause;
        int       stall_len;
    } vec_t;

    vec_t vt[11];

    initial begin
        int       n;
        bit [3:0] r_irq;

        vt[0]  = '{1, 0, 0, 0, 1, 1, 0, 5'h08, 3};
        vt[1]  = '{0, 1, 0, 0, 1, 1, 0, 5'h09, 3};
        vt[2]  = '{0, 0, 1, 0, 1, 1, 0, 5'h0d, 3};
        vt[3]  = '{0, 0, 0, 1, 1, 0, 1, 5'h00, 3};
        vt[4]  = '{0, 0, 0, 1, 0, 0, 1, 5'h00, 3};
        vt[5]  = '{1, 0, 0, 0, 0, 0, 0, 5'h00, 0};
        vt[6]  = '{1, 1, 0, 1, 1, 1, 0, 5'h08, 3};
        vt[7]  = '{0, 1, 1, 0, 1, 1, 0, 5'h09, 3};
        vt[8]  = '{0, 0, 1, 1, 1, 1, 0, 5'h0d, 3};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 0, 5'h00, 0};
        vt[10] = '{0, 1, 0, 0, 0, 0, 0, 5'h00, 0};

        reset           = 1'b0;
        bus.syscall_req = 1'b0;
        bus.break_req   = 1'b0;
        bus.teq_req     = 1'b0;
        bus.eret_req    = 1'b0;
        bus.irq         = '0;
        bus.status_ie   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_exception", bus.exception, 1'b0);
        chk("rst_eret", bus.eret, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pending", bus.irq_pending, 4'b0000);
        chk("rst_cause", bus.cause, 5'h00);
        reset = 1'b1;
        model_reset();
        step();

        // Single-shot sync requests from IDLE.
        for (int i = 0; i < 11; i++) begin
            bus.syscall_req = vt[i].sys;
            bus.break_req   = vt[i].brk;
            bus.teq_req     = vt[i].teq;
            bus.eret_req    = vt[i].ert;
            bus.status_ie   = vt[i].ie;
            step();
            chk($sformatf("vec%0d_exc", i), bus.exception, vt[i].exc);
            chk($sformatf("vec%0d_eret", i), bus.eret, vt[i].ert_o);
            if (vt[i].exc) chk($sformatf("vec%0d_cause", i), bus.cause, vt[i].cause);
            chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].stall_len != 0);
            bus.syscall_req = 1'b0;
            bus.break_req   = 1'b0;
            bus.teq_req     = 1'b0;
            bus.eret_req    = 1'b0;
            n = 0;
            while (bus.stall && n < 20) begin
                n++;
                step();
            end
            chk($sformatf("vec%0d_stall_len", i), n, vt[i].stall_len);
            step();
        end

        // Syscall held while the IR is frozen: one pulse, stall for 1+HOLD cycles.
        bus.status_ie   = 1'b1;
        bus.syscall_req = 1'b1;
        step();
        chk("a_exc", bus.exception, 1'b1);
        chk("a_cause", bus.cause, 5'h08);
        chk("a_stall0", bus.stall, 1'b1);
        step();
        chk("a_exc_once", bus.exception, 1'b0);
        chk("a_stall1", bus.stall, 1'b1);
        step();
        chk("a_stall2", bus.stall, 1'b1);
        bus.syscall_req = 1'b0;
        step();
        chk("a_stall3", bus.stall, 1'b0);
        chk("a_busy3", bus.busy, 1'b0);
        step();

        // Two IRQ edges in one cycle: lowest index serviced first, the other after IDLE.
        bus.irq = 4'b0110;
        step();
        repeat (SYNC_DLY) step();
        chk("b_pend_both", bus.irq_pending, 4'b0110);
        chk("b_no_exc_yet", bus.exception, 1'b0);
        bus.irq = 4'b0000;
        step();
        chk("b_exc1", bus.exception, 1'b1);
        chk("b_cause1", bus.cause, 5'h00);
        chk("b_pend1", bus.irq_pending, 4'b0100);
        repeat (4) step();
        chk("b_exc2", bus.exception, 1'b1);
        chk("b_cause2", bus.cause, 5'h00);
        chk("b_pend2", bus.irq_pending, 4'b0000);
        wait_idle("b");
        step();

        // IRQ with interrupts disabled stays pending until status_ie rises.
        bus.status_ie = 1'b0;
        bus.irq       = 4'b0001;
        step();
        repeat (SYNC_DLY) step();
        chk("c_pend", bus.irq_pending, 4'b0001);
        chk("c_exc_masked", bus.exception, 1'b0);
        step();
        step();
        chk("c_still_masked", bus.exception, 1'b0);
        chk("c_no_stall", bus.stall, 1'b0);
        chk("c_pend_kept", bus.irq_pending, 4'b0001);
        bus.status_ie = 1'b1;
        step();
        chk("c_exc", bus.exception, 1'b1);
        chk("c_pend_clr", bus.irq_pending, 4'b0000);
        bus.irq = 4'b0000;
        wait_idle("c");
        step();

        // New edge on the line being serviced keeps its pending bit set.
        bus.status_ie = 1'b0;
        bus.irq       = 4'b0010;
        step();
        repeat (SYNC_DLY) step();
        chk("f_pend_set", bus.irq_pending, 4'b0010);
        bus.irq = 4'b0000;
        repeat (1 + SYNC_DLY) step();
        bus.irq = 4'b0010;
        repeat (SYNC_DLY) step();
        bus.status_ie = 1'b1;
        step();
        chk("f_exc", bus.exception, 1'b1);
        chk("f_pend_rearmed", bus.irq_pending, 4'b0010);
        bus.irq = 4'b0000;
        wait_idle("f1");
        step();
        chk("f_exc2", bus.exception, 1'b1);
        chk("f_pend_done", bus.irq_pending, 4'b0000);
        wait_idle("f2");
        step();

        // Asynchronous reset during HOLD drops stall and the latched IRQ at once.
        bus.syscall_req = 1'b1;
        step();
        bus.syscall_req = 1'b0;
        bus.irq         = 4'b1000;
        step();
        chk("e_in_hold", bus.stall, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("e_stall", bus.stall, 1'b0);
        chk("e_busy", bus.busy, 1'b0);
        chk("e_pend", bus.irq_pending, 4'b0000);
        model_reset();
        bus.irq = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        step();

        // Random traffic against the reference model.
        r_irq = '0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NIRQ; k++) begin
                if ($urandom_range(0, 3) == 0) r_irq[k] = ~r_irq[k];
            end
            bus.irq         = r_irq;
            bus.status_ie   = ($urandom_range(0, 4) != 0);
            bus.syscall_req = ($urandom_range(0, 9) == 0);
            bus.break_req   = ($urandom_range(0, 9) == 0);
            bus.teq_req     = ($urandom_range(0, 9) == 0);
            bus.eret_req    = ($urandom_range(0, 9) == 0);
            if (!bus.status_ie && (bus.syscall_req || bus.break_req || bus.teq_req)) bus.eret_req = 1'b0;
            step();
            chk("rnd_exc", bus.exception, m_exc);
            chk("rnd_eret", bus.eret, m_eret);
            chk("rnd_stall", bus.stall, m_left > 0);
            chk("rnd_busy", bus.busy, m_left > 0);
            chk("rnd_pend", bus.irq_pending, m_pend);
            if (m_exc) chk("rnd_cause", bus.cause, m_cause);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
